stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Single-clock control and sequencing block for the MIN:SEC stopwatch counter. It turns the board clock and the raw button and switch inputs into clean one-cycle enables: a 1 Hz run increment, a 2 Hz adjust increment per field, a counter clear, a display scan tick and a field-blink mask. It owns the RUN/PAUSE/ADJ mode so the counter datapath runs in one clock domain and holds no mode state of its own.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency
- INC_HZ, 1, run-mode increment rate
- ADJ_HZ, 2, adjust-mode increment rate
- BLINK_HZ, 4, blink phase toggle rate
- SCAN_HZ, 500, display digit-scan tick rate
- DB_CYCLES, 2_000_000, stable cycles required to accept a button level

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- btnPause  in  1  raw pause button, asynchronous
- btnRst  in  1  raw clear button, asynchronous
- swAdj  in  1  raw adjust switch, asynchronous
- swSel  in  1  raw select switch (0 = minutes, 1 = seconds), asynchronous
- incEn  out  1  one-cycle pulse: advance MIN:SEC by one second
- adjMinEn  out  1  one-cycle pulse: advance minutes (wrap handled by counter)
- adjSecEn  out  1  one-cycle pulse: advance seconds
- clrCnt  out  1  one-cycle pulse: clear counter to 00:00
- scanEn  out  1  one-cycle display scan tick
- blankMin  out  1  blank the minutes digits this phase
- blankSec  out  1  blank the seconds digits this phase
- mode  out  2  current state: RUN = 0, PAUSE = 1, ADJ = 2

## Operation
- Inputs: all four raw inputs pass through 2-FF synchronizers. btnPause and btnRst are then debounced: the accepted level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles. A rising edge of the accepted level gives one press pulse.
- Dividers: each divider counts 0..(CLK_HZ/rate − 1) and pulses on its terminal count. Counter width is $clog2(CLK_HZ/rate).
- Divider enables:
  - INC divider counts only in RUN and holds at 0 otherwise, so resume yields a full second before the next incEn.
  - ADJ divider counts only in ADJ and is cleared on ADJ entry.
  - SCAN and BLINK dividers are free-running.
- State flag: pauseFlag is a 1-bit saved flag.
- FSM transitions, evaluated each cycle in priority order:
  1. clear press: clrCnt = 1, pauseFlag = 0, next = swAdj ? ADJ : RUN, INC and ADJ dividers cleared.
  2. swAdj = 1: next = ADJ.
  3. In ADJ with swAdj = 0: next = pauseFlag ? PAUSE : RUN.
  4. Pause press in RUN: go to PAUSE and set pauseFlag. Pause press in PAUSE: go to RUN and clear pauseFlag.
- Pause presses while in ADJ are ignored.
- Adjust pulses: in ADJ, an ADJ divider pulse drives adjMinEn if swSel = 0, otherwise adjSecEn. Both are never high together.
- swSel change mid-ADJ: the ADJ divider is not restarted.
- incEn, adjMinEn and adjSecEn are mutually exclusive by construction. clrCnt may coincide with none of them: divider pulses are suppressed in the clear cycle.

## Timing
- Reset values: every output is 0 and mode = RUN. Dividers, debouncers, synchronizers and pauseFlag are cleared. The blink phase resets to 0.
- All outputs are registered and pulses are exactly one cycle wide.
- Button latency: a clean raw rise at edge 0 that is held produces the press effect (mode change or clrCnt) visible DB_CYCLES+3 edges later.
- Switch latency: swAdj and swSel take effect 3 edges after the raw change (2-FF sync plus state register).
- Asynchronous rst mid-count: everything returns to the reset values immediately, and the first incEn comes CLK_HZ/INC_HZ cycles after rst deassertion.

## Configuration
- STOPWATCH_BLINK_EN defined: the BLINK divider toggles the blink phase on each BLINK_HZ tick.
  - blankMin = (mode == ADJ) & ~swSel & phase.
  - blankSec = (mode == ADJ) & swSel & phase.
- STOPWATCH_BLINK_EN undefined: the BLINK divider and phase are not built, and blankMin and blankSec are tied to 0.

## Structure
- stopwatch_pkg holds:
  - the mode enum (RUN, PAUSE, ADJ) and its 2-bit width;
  - default rate constants (INC_HZ, ADJ_HZ, BLINK_HZ, SCAN_HZ);
  - the default DB_CYCLES.
- btn_debounce sub-module (synchronizer, debounce counter, rising-edge press pulse) is instantiated twice.

## Test plan
Bench parameters: CLK_HZ = 100, INC_HZ = 1, ADJ_HZ = 2, BLINK_HZ = 4, SCAN_HZ = 50, DB_CYCLES = 4.
- Reset release, inputs idle: incEn pulses at cycles 100, 200, 300; scanEn every 2 cycles; mode = 0; no other pulses.
- Clean btnPause press at cycle 150: mode becomes 1 at cycle 157 and incEn is absent. A second press leads to the next incEn 100 cycles after mode returns to 0.
- btnPause glitch high for 3 cycles: no mode change. Held for 10 cycles: exactly one toggle.
- swAdj = 1 with swSel = 0: mode = 2 and adjMinEn every 50 cycles. Switch swSel to 1 and adjSecEn follows with no adjMinEn. With blink enabled, blankMin toggles every 25 cycles.
- Pause, then swAdj 1 → 0: mode returns to 1, not 0. btnRst press in the same cycle as a pause press: a single clrCnt, mode = 0, pause ignored.
- rst asserted mid-ADJ: all outputs 0 and mode = 0 in the same cycle. After release, the first incEn arrives at cycle 100.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control block.
package stopwatch_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    ADJ   = 2'd2
  } mode_e;

  localparam int unsigned DEF_INC_HZ    = 1;
  localparam int unsigned DEF_ADJ_HZ    = 2;
  localparam int unsigned DEF_BLINK_HZ  = 4;
  localparam int unsigned DEF_SCAN_HZ   = 500;
  localparam int unsigned DEF_DB_CYCLES = 2_000_000;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Raw button/switch inputs and registered enable/mode outputs of stopwatch_ctrl.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic              btnPause;
  logic              btnRst;
  logic              swAdj;
  logic              swSel;
  logic              incEn;
  logic              adjMinEn;
  logic              adjSecEn;
  logic              clrCnt;
  logic              scanEn;
  logic              blankMin;
  logic              blankSec;
  logic [MODE_W-1:0] mode;

  modport master (
    output btnPause, btnRst, swAdj, swSel,
    input  incEn, adjMinEn, adjSecEn, clrCnt, scanEn, blankMin, blankSec, mode
  );

  modport slave (
    input  btnPause, btnRst, swAdj, swSel,
    output incEn, adjMinEn, adjSecEn, clrCnt, scanEn, blankMin, blankSec, mode
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, level debounce, rising-edge press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int unsigned    CW   = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_lvl_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      // Any agreeing sample restarts the stability run.
      if (r_s2 != r_lvl) begin
        if (r_cnt == LAST) begin
          r_lvl <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// RUN/PAUSE/ADJ sequencer and rate dividers for the MIN:SEC stopwatch.
// Blink phase and field blanking are built only with STOPWATCH_BLINK_EN defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned INC_HZ    = DEF_INC_HZ,
  parameter int unsigned ADJ_HZ    = DEF_ADJ_HZ,
  parameter int unsigned BLINK_HZ  = DEF_BLINK_HZ,
  parameter int unsigned SCAN_HZ   = DEF_SCAN_HZ,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  if (INC_HZ == 0 || ADJ_HZ == 0 || BLINK_HZ == 0 || SCAN_HZ == 0 || DB_CYCLES == 0 ||
      CLK_HZ < INC_HZ || CLK_HZ < ADJ_HZ || CLK_HZ < BLINK_HZ || CLK_HZ < SCAN_HZ) begin : g_bad_cfg
    $error("stopwatch_ctrl: rates must be nonzero and not exceed CLK_HZ");
  end

  localparam int unsigned        INC_N     = CLK_HZ / INC_HZ;
  localparam int unsigned        ADJ_N     = CLK_HZ / ADJ_HZ;
  localparam int unsigned        SCAN_N    = CLK_HZ / SCAN_HZ;
  localparam int unsigned        INC_W     = cnt_width(INC_N);
  localparam int unsigned        ADJ_W     = cnt_width(ADJ_N);
  localparam int unsigned        SCAN_W    = cnt_width(SCAN_N);
  localparam logic [INC_W-1:0]   INC_LAST  = INC_W'(INC_N - 1);
  localparam logic [ADJ_W-1:0]   ADJ_LAST  = ADJ_W'(ADJ_N - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_N - 1);

  logic              w_press_pause;
  logic              w_press_clr;
  logic              r_adj_s1, r_adj_s2;
  logic              r_sel_s1, r_sel_s2;
  mode_e             r_mode, w_next;
  logic              r_pflag, w_pflag_next;
  logic              w_inc_hit, w_adj_hit;
  logic [INC_W-1:0]  r_inc_cnt;
  logic [ADJ_W-1:0]  r_adj_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_inc, r_adj_min, r_adj_sec, r_clr, r_scan;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.btnPause),
    .o_press (w_press_pause)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.btnRst),
    .o_press (w_press_clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adj_s1 <= 1'b0;
      r_adj_s2 <= 1'b0;
      r_sel_s1 <= 1'b0;
      r_sel_s2 <= 1'b0;
      r_mode   <= RUN;
      r_pflag  <= 1'b0;
    end else begin
      r_adj_s1 <= bus.swAdj;
      r_adj_s2 <= r_adj_s1;
      r_sel_s1 <= bus.swSel;
      r_sel_s2 <= r_sel_s1;
      r_mode   <= w_next;
      r_pflag  <= w_pflag_next;
    end
  end

  always_comb begin
    w_next       = r_mode;
    w_pflag_next = r_pflag;
    if (w_press_clr) begin
      w_next       = r_adj_s2 ? ADJ : RUN;
      w_pflag_next = 1'b0;
    end else if (r_adj_s2) begin
      w_next = ADJ;
    end else if (r_mode == ADJ) begin
      w_next = r_pflag ? PAUSE : RUN;
    end else if (w_press_pause) begin
      if (r_mode == RUN) begin
        w_next       = PAUSE;
        w_pflag_next = 1'b1;
      end else begin
        w_next       = RUN;
        w_pflag_next = 1'b0;
      end
    end
    // A terminal count on the mode-exit edge is dropped rather than leaking out.
    w_inc_hit = (r_mode == RUN) && (w_next == RUN) && !w_press_clr && (r_inc_cnt == INC_LAST);
    w_adj_hit = (r_mode == ADJ) && (w_next == ADJ) && !w_press_clr && (r_adj_cnt == ADJ_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inc_cnt  <= '0;
      r_adj_cnt  <= '0;
      r_scan_cnt <= '0;
      r_inc      <= 1'b0;
      r_adj_min  <= 1'b0;
      r_adj_sec  <= 1'b0;
      r_clr      <= 1'b0;
      r_scan     <= 1'b0;
    end else begin
      if (r_mode == RUN && !w_press_clr)
        r_inc_cnt <= (r_inc_cnt == INC_LAST) ? '0 : r_inc_cnt + 1'b1;
      else
        r_inc_cnt <= '0;
      if (r_mode == ADJ && !w_press_clr)
        r_adj_cnt <= (r_adj_cnt == ADJ_LAST) ? '0 : r_adj_cnt + 1'b1;
      else
        r_adj_cnt <= '0;
      r_scan_cnt <= (r_scan_cnt == SCAN_LAST) ? '0 : r_scan_cnt + 1'b1;
      r_inc      <= w_inc_hit;
      r_adj_min  <= w_adj_hit & ~r_sel_s2;
      r_adj_sec  <= w_adj_hit & r_sel_s2;
      r_clr      <= w_press_clr;
      r_scan     <= (r_scan_cnt == SCAN_LAST);
    end
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int unsigned        BLINK_N    = CLK_HZ / BLINK_HZ;
  localparam int unsigned        BLINK_W    = cnt_width(BLINK_N);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;
  logic               w_phase_next;
  logic               r_blank_min, r_blank_sec;

  assign w_phase_next = r_phase ^ (r_blink_cnt == BLINK_LAST);

  // Blanking uses next-state values so it lines up with the registered mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
    end else begin
      r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
      r_phase     <= w_phase_next;
      r_blank_min <= (w_next == ADJ) & ~r_sel_s2 & w_phase_next;
      r_blank_sec <= (w_next == ADJ) & r_sel_s2 & w_phase_next;
    end
  end

  assign bus.blankMin = r_blank_min;
  assign bus.blankSec = r_blank_sec;
`else
  assign bus.blankMin = 1'b0;
  assign bus.blankSec = 1'b0;
`endif

  assign bus.incEn    = r_inc;
  assign bus.adjMinEn = r_adj_min;
  assign bus.adjSecEn = r_adj_sec;
  assign bus.clrCnt   = r_clr;
  assign bus.scanEn   = r_scan;
  assign bus.mode     = r_mode;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized stimulus for stopwatch_ctrl against a timestamp-based reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ   = 100;
  localparam int unsigned INC_HZ   = 1;
  localparam int unsigned ADJ_HZ   = 2;
  localparam int unsigned BLINK_HZ = 4;
  localparam int unsigned SCAN_HZ  = 50;
  localparam int unsigned DB       = 4;

  localparam int INC_P   = CLK_HZ / INC_HZ;
  localparam int ADJ_P   = CLK_HZ / ADJ_HZ;
  localparam int SCAN_P  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_P = CLK_HZ / BLINK_HZ;
  localparam int M_RUN   = 0;
  localparam int M_PAUSE = 1;
  localparam int M_ADJ   = 2;

  logic clk = 1'b0;
  logic rst;
  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .INC_HZ    (INC_HZ),
    .ADJ_HZ    (ADJ_HZ),
    .BLINK_HZ  (BLINK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .DB_CYCLES (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference state: edge index since reset release and mode-entry timestamps.
  int n;
  int m_mode, m_pflag, run_start, adj_start;
  bit h [4][0:8191];
  int db_lvl [2];
  int db_run [2];
  bit db_rose [2];
  bit e_inc, e_min, e_sec, e_clr, e_scan, e_bmin, e_bsec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit past(input int ch, input int k);
    return (k >= 1) ? h[ch][k] : 1'b0;
  endfunction

  task automatic model_reset();
    n = 0; m_mode = M_RUN; m_pflag = 0; run_start = 0; adj_start = 0;
    for (int b = 0; b < 2; b++) begin
      db_lvl[b] = 0; db_run[b] = 0; db_rose[b] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit adj_e, sel_e, clr, pp;
    bit press [2];
    int nxt;
    n++;
    h[0][n] = bus.btnPause;
    h[1][n] = bus.btnRst;
    h[2][n] = bus.swAdj;
    h[3][n] = bus.swSel;
    // Switches act on the value sampled two edges back; buttons need DB stable samples.
    adj_e = past(2, n - 2);
    sel_e = past(3, n - 2);
    for (int b = 0; b < 2; b++) begin
      int obs;
      press[b] = db_rose[b];
      obs = int'(past(b, n - 2));
      if (obs != db_lvl[b]) begin
        db_run[b]++;
        if (db_run[b] == int'(DB)) begin
          db_lvl[b] = obs; db_run[b] = 0; db_rose[b] = (obs == 1);
        end else db_rose[b] = 1'b0;
      end else begin
        db_run[b] = 0; db_rose[b] = 1'b0;
      end
    end
    pp  = press[0];
    clr = press[1];
    nxt = m_mode;
    if (clr) begin
      nxt = adj_e ? M_ADJ : M_RUN; m_pflag = 0;
    end else if (adj_e) nxt = M_ADJ;
    else if (m_mode == M_ADJ) nxt = m_pflag ? M_PAUSE : M_RUN;
    else if (pp && m_mode == M_RUN) begin nxt = M_PAUSE; m_pflag = 1; end
    else if (pp && m_mode == M_PAUSE) begin nxt = M_RUN; m_pflag = 0; end
    e_clr  = clr;
    e_inc  = !clr && m_mode == M_RUN && nxt == M_RUN && ((n - run_start) % INC_P == 0);
    e_min  = !clr && m_mode == M_ADJ && nxt == M_ADJ && ((n - adj_start) % ADJ_P == 0) && !sel_e;
    e_sec  = !clr && m_mode == M_ADJ && nxt == M_ADJ && ((n - adj_start) % ADJ_P == 0) && sel_e;
    e_scan = (n % SCAN_P == 0);
`ifdef STOPWATCH_BLINK_EN
    e_bmin = (nxt == M_ADJ) && !sel_e && ((n / BLINK_P) % 2 == 1);
    e_bsec = (nxt == M_ADJ) && sel_e && ((n / BLINK_P) % 2 == 1);
`else
    e_bmin = 1'b0;
    e_bsec = 1'b0;
`endif
    if (clr || (nxt == M_RUN && m_mode != M_RUN)) run_start = n;
    if (clr || (nxt == M_ADJ && m_mode != M_ADJ)) adj_start = n;
    m_mode = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("incEn", bus.incEn, e_inc);
    check("adjMinEn", bus.adjMinEn, e_min);
    check("adjSecEn", bus.adjSecEn, e_sec);
    check("clrCnt", bus.clrCnt, e_clr);
    check("scanEn", bus.scanEn, e_scan);
    check("blankMin", bus.blankMin, e_bmin);
    check("blankSec", bus.blankSec, e_bsec);
    check("mode", bus.mode, m_mode);
  endtask

  task automatic do_reset();
    bus.btnPause = 1'b0; bus.btnRst = 1'b0; bus.swAdj = 1'b0; bus.swSel = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_incEn", bus.incEn, 0);
    check("rst_adjMinEn", bus.adjMinEn, 0);
    check("rst_adjSecEn", bus.adjSecEn, 0);
    check("rst_clrCnt", bus.clrCnt, 0);
    check("rst_scanEn", bus.scanEn, 0);
    check("rst_blankMin", bus.blankMin, 0);
    check("rst_blankSec", bus.blankSec, 0);
    check("rst_mode", bus.mode, M_RUN);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int mode_before, cnt_a, cnt_b, first_inc;
    int unsigned pick, hold, glitch;
    rst = 1'b0;
    bus.btnPause = 1'b0; bus.btnRst = 1'b0; bus.swAdj = 1'b0; bus.swSel = 1'b0;
    #2;
    do_reset();

    // Idle run: first incEn exactly one period after release.
    repeat (99) step();
    check("inc_not_before_100", bus.incEn, 0);
    step();
    check("inc_at_100", bus.incEn, 1);
    repeat (50) step();
    bus.btnPause = 1'b1;
    repeat (6) step();
    check("mode_before_157", bus.mode, M_RUN);
    step();
    check("mode_at_157", bus.mode, M_PAUSE);
    repeat (5) step();
    bus.btnPause = 1'b0;
    repeat (20) step();
    bus.btnPause = 1'b1;
    repeat (10) step();
    bus.btnPause = 1'b0;
    repeat (120) step();
    check("resumed_run", bus.mode, M_RUN);

    // Short glitch is rejected, a held press toggles once.
    mode_before = int'(bus.mode);
    glitch = $urandom_range(1, DB - 1);
    bus.btnPause = 1'b1;
    repeat (glitch) step();
    bus.btnPause = 1'b0;
    repeat (20) step();
    check("glitch_no_toggle", bus.mode, mode_before);
    bus.btnPause = 1'b1;
    repeat (10) step();
    bus.btnPause = 1'b0;
    repeat (20) step();
    check("held_one_toggle", bus.mode, M_PAUSE);

    // Adjust minutes, then seconds, then leave ADJ back to the saved PAUSE.
    bus.swAdj = 1'b1; bus.swSel = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      cnt_a += int'(bus.adjMinEn);
      cnt_b += int'(bus.adjSecEn);
    end
    check("adj_min_pulses", cnt_a, 2);
    check("adj_sec_none", cnt_b, 0);
    bus.swSel = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      cnt_a += int'(bus.adjMinEn);
      cnt_b += int'(bus.adjSecEn);
    end
    check("adj_min_none", cnt_a, 0);
    check("adj_sec_pulses", cnt_b, 2);
    bus.swAdj = 1'b0;
    repeat (5) step();
    check("adj_exit_to_pause", bus.mode, M_PAUSE);

    // Clear and pause pressed together: clear wins, one pulse.
    bus.btnRst = 1'b1; bus.btnPause = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      cnt_a += int'(bus.clrCnt);
    end
    bus.btnRst = 1'b0; bus.btnPause = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      cnt_a += int'(bus.clrCnt);
    end
    check("single_clr", cnt_a, 1);
    check("clr_mode_run", bus.mode, M_RUN);

    // Randomized input activity.
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 3);
      hold = $urandom_range(1, 25);
      case (pick)
        0: bus.btnPause = ~bus.btnPause;
        1: bus.btnRst   = ~bus.btnRst;
        2: bus.swAdj    = ~bus.swAdj;
        default: bus.swSel = ~bus.swSel;
      endcase
      repeat (hold) step();
    end

    // Asynchronous reset in the middle of ADJ.
    bus.btnPause = 1'b0; bus.btnRst = 1'b0; bus.swSel = 1'b0;
    bus.swAdj = 1'b1;
    repeat (30) step();
    check("pre_rst_adj", bus.mode, M_ADJ);
    do_reset();
    first_inc = -1;
    for (int i = 0; i < 105; i++) begin
      step();
      if (bus.incEn === 1'b1 && first_inc < 0) first_inc = n;
    end
    check("first_inc_after_rst", first_inc, 100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
